// File: rtl/fetch_sequencer.sv
// Fetch path sequencer: owns the PC, issues req/ack reads, hands instructions to decode.
// Optional FETCH_COUNT_EN adds a saturating delivered-instruction counter (fetch_count).
module fetch_sequencer #(
    parameter int              ADDR_W      = 8,
    parameter int              DATA_W      = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [3:0]      HALT_OPCODE = 4'hF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
`ifdef FETCH_COUNT_EN
    ,
    output logic [15:0]       fetch_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_PAUSE,
        S_HALT
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_inc_d;
    logic                mem_req_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                inst_valid_q;
    logic [DATA_W-1:0]   inst_data_q;
    logic [ADDR_W-1:0]   inst_pc_q;
    logic                halted_q;
    logic                kill_q;
    logic                hs_d;
    logic                is_halt_d;
    state_e              resume_d;

    assign pc_inc_d  = pc_q + ADDR_W'(1);
    assign is_halt_d = (inst_data_q[DATA_W-1 -: 4] == HALT_OPCODE);
    assign resume_d  = stall ? S_PAUSE : S_REQ;
    // A redirect in HOLD flushes the instruction, so it never counts as delivered.
    assign hs_d      = (state_q == S_HOLD) & inst_valid_q & inst_ready
                     & ~redirect_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            inst_valid_q <= 1'b0;
            inst_data_q  <= '0;
            inst_pc_q    <= '0;
            halted_q     <= 1'b0;
            kill_q       <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                    end else if (start) begin
                        if (stall) begin
                            state_q <= S_PAUSE;
                        end else begin
                            state_q    <= S_REQ;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= pc_q;
                        end
                    end
                end
                S_REQ: begin
                    if (!mem_req_q) begin
                        if (redirect_valid) begin
                            pc_q <= redirect_pc;
                        end else begin
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= pc_q;
                        end
                    end else if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (redirect_valid || kill_q) begin
                            kill_q  <= 1'b0;
                            state_q <= resume_d;
                            if (redirect_valid) begin
                                pc_q <= redirect_pc;
                            end
                        end else begin
                            inst_valid_q <= 1'b1;
                            inst_data_q  <= mem_rdata;
                            inst_pc_q    <= mem_addr_q;
                            pc_q         <= pc_inc_d;
                            state_q      <= S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        pc_q   <= redirect_pc;
                        kill_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        inst_valid_q <= 1'b0;
                        pc_q         <= redirect_pc;
                        state_q      <= resume_d;
                    end else if (inst_ready) begin
                        inst_valid_q <= 1'b0;
                        if (is_halt_d) begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= resume_d;
                        end
                    end
                end
                S_PAUSE: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                    end else if (!stall) begin
                        state_q <= S_REQ;
                    end
                end
                S_HALT: begin
                    if (redirect_valid) begin
                        pc_q     <= redirect_pc;
                        halted_q <= 1'b0;
                        state_q  <= resume_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef FETCH_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (hs_d && count_q != 16'hFFFF) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign fetch_count = count_q;
`else
    logic unused_hs;
    assign unused_hs = hs_d;
`endif

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign inst_valid = inst_valid_q;
    assign inst_data  = inst_data_q;
    assign inst_pc    = inst_pc_q;
    assign pc         = pc_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a req/ack memory model of programmable latency.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stall;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       inst_valid;
    logic [7:0] inst_data;
    logic [7:0] inst_pc;
    logic       inst_ready;
    logic [7:0] pc;
    logic       halted;
`ifdef FETCH_COUNT_EN
    logic [15:0] fetch_count;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wait_cnt = 0;
    int ack_delay = 0;
    logic ack_force = 1'b0;
    logic [7:0] mem [256];
    logic [15:0] hs_q [$];
    int hs_cyc [$];

    fetch_sequencer dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .inst_valid(inst_valid),
        .inst_data(inst_data),
        .inst_pc(inst_pc),
        .inst_ready(inst_ready),
        .pc(pc),
        .halted(halted)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count(fetch_count)
`endif
    );

    always #5 clk = ~clk;

    assign mem_ack   = (mem_req && wait_cnt >= ack_delay) || ack_force;
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    // Handshakes are sampled mid-cycle; a concurrent redirect flushes them.
    always @(negedge clk) begin
        if (inst_valid && inst_ready && !redirect_valid && !reset) begin
            hs_q.push_back({inst_pc, inst_data});
            hs_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_halt(input string name);
        int n = 0;
        while (!halted && n < 60) begin
            tick();
            n++;
        end
        total++;
        if (halted !== 1'b1) begin
            bad++;
            $display("FAIL %s halt timeout got=%b want=1", name, halted);
        end
    endtask

    task automatic redirect_to(input logic [7:0] a);
        redirect_valid = 1'b1;
        redirect_pc = a;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        start = 0; stall = 0; redirect_valid = 0; redirect_pc = 0;
        inst_ready = 0; reset = 1;
        repeat (2) tick();
        reset = 0;
        tick();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", mem_req); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", inst_valid); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b want=0", halted); end
        total++; if (pc !== 8'h00) begin bad++; $display("FAIL rst_pc got=%h want=00", pc); end
        total++; if (mem_addr !== 8'h00) begin bad++; $display("FAIL rst_addr got=%h want=00", mem_addr); end
    endtask

    task automatic test_basic();
        logic [15:0] exp [3];
        int reqs = 0;
        exp[0] = 16'h0011; exp[1] = 16'h0122; exp[2] = 16'h02F0;
        hs_q.delete(); hs_cyc.delete();
        ack_delay = 0; inst_ready = 1;
        start = 1;
        tick();
        start = 0;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL basic_req1 got=%b want=1", mem_req); end
        total++; if (mem_addr !== 8'h00) begin bad++; $display("FAIL basic_addr1 got=%h want=00", mem_addr); end
        tick();
        total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL basic_valid2 got=%b want=1", inst_valid); end
        total++; if (inst_data !== 8'h11) begin bad++; $display("FAIL basic_data2 got=%h want=11", inst_data); end
        wait_halt("basic");
        total++;
        if (hs_q.size() != 3) begin
            bad++; $display("FAIL basic_count got=%0d want=3", hs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (hs_q[i] !== exp[i]) begin bad++; $display("FAIL basic_seq%0d got=%h want=%h", i, hs_q[i], exp[i]); end
            end
            total++;
            if (hs_cyc[1] - hs_cyc[0] != 3 || hs_cyc[2] - hs_cyc[1] != 3) begin
                bad++; $display("FAIL basic_rate got=%0d,%0d want=3,3", hs_cyc[1] - hs_cyc[0], hs_cyc[2] - hs_cyc[1]);
            end
        end
        total++; if (pc !== 8'h03) begin bad++; $display("FAIL basic_pc got=%h want=03", pc); end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (mem_req) reqs++;
        end
        total++; if (reqs != 0) begin bad++; $display("FAIL basic_noreq got=%0d want=0", reqs); end
`ifdef FETCH_COUNT_EN
        total++; if (fetch_count !== 16'd3) begin bad++; $display("FAIL basic_fcnt got=%0d want=3", fetch_count); end
`endif
    endtask

    task automatic test_delay();
        int n = 0;
        logic stable = 1'b1;
        hs_q.delete();
        mem[8'h10] = 8'h33; mem[8'h11] = 8'h44; mem[8'h12] = 8'hF5;
        ack_delay = 3; inst_ready = 0;
        redirect_to(8'h10);
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL dly_unhalt got=%b want=0", halted); end
        tick();
        total++; if (mem_req !== 1'b1 || mem_addr !== 8'h10) begin bad++; $display("FAIL dly_issue got=%b/%h want=1/10", mem_req, mem_addr); end
        while (!mem_ack && n < 10) begin
            tick();
            n++;
            if (mem_req !== 1'b1 || mem_addr !== 8'h10) stable = 1'b0;
        end
        total++; if (stable !== 1'b1 || n != 3) begin bad++; $display("FAIL dly_stable got=%b/%0d want=1/3", stable, n); end
        repeat (3) tick();
        total++; if (inst_valid !== 1'b1 || inst_data !== 8'h33 || inst_pc !== 8'h10) begin
            bad++; $display("FAIL dly_hold got=%b/%h/%h want=1/33/10", inst_valid, inst_data, inst_pc);
        end
        inst_ready = 1;
        wait_halt("dly");
        total++;
        if (hs_q.size() != 3 || hs_q[0] !== 16'h1033 || hs_q[1] !== 16'h1144 || hs_q[2] !== 16'h12F5) begin
            bad++; $display("FAIL dly_seq got=%0d entries first=%h want=3 first=1033", hs_q.size(), hs_q.size() > 0 ? hs_q[0] : 16'h0);
        end
    endtask

    task automatic test_kill();
        int n = 0;
        hs_q.delete();
        mem[8'h20] = 8'h55; mem[8'h40] = 8'h66; mem[8'h41] = 8'hF1;
        ack_delay = 2; inst_ready = 1;
        redirect_to(8'h20);
        tick();
        tick();
        redirect_to(8'h40);
        total++; if (pc !== 8'h40) begin bad++; $display("FAIL kill_pc got=%h want=40", pc); end
        while (mem_req && n < 10) begin tick(); n++; end
        n = 0;
        while (!mem_req && n < 10) begin tick(); n++; end
        total++; if (mem_req !== 1'b1 || mem_addr !== 8'h40) begin bad++; $display("FAIL kill_addr got=%b/%h want=1/40", mem_req, mem_addr); end
        wait_halt("kill");
        total++;
        if (hs_q.size() != 2 || hs_q[0] !== 16'h4066 || hs_q[1] !== 16'h41F1) begin
            bad++; $display("FAIL kill_seq got=%0d entries first=%h want=2 first=4066", hs_q.size(), hs_q.size() > 0 ? hs_q[0] : 16'h0);
        end
    endtask

    task automatic test_flush();
`ifdef FETCH_COUNT_EN
        logic [15:0] before;
`endif
        hs_q.delete();
        mem[8'h30] = 8'h77; mem[8'h80] = 8'h88; mem[8'h81] = 8'hF2;
        ack_delay = 0; inst_ready = 1;
        redirect_to(8'h30);
        tick();
        tick();
        total++; if (inst_valid !== 1'b1 || inst_pc !== 8'h30) begin bad++; $display("FAIL flush_hold got=%b/%h want=1/30", inst_valid, inst_pc); end
`ifdef FETCH_COUNT_EN
        before = fetch_count;
`endif
        redirect_to(8'h80);
        total++; if (inst_valid !== 1'b0 || pc !== 8'h80) begin bad++; $display("FAIL flush_drop got=%b/%h want=0/80", inst_valid, pc); end
        wait_halt("flush");
        total++;
        if (hs_q.size() != 2 || hs_q[0] !== 16'h8088 || hs_q[1] !== 16'h81F2) begin
            bad++; $display("FAIL flush_seq got=%0d entries first=%h want=2 first=8088", hs_q.size(), hs_q.size() > 0 ? hs_q[0] : 16'h0);
        end
`ifdef FETCH_COUNT_EN
        total++; if (fetch_count !== before + 16'd2) begin bad++; $display("FAIL flush_fcnt got=%0d want=%0d", fetch_count, before + 16'd2); end
`endif
    endtask

    task automatic test_wrap_stall();
        int n = 0;
        int reqs = 0;
        mem[8'hFF] = 8'h99;
        ack_delay = 0; inst_ready = 0;
        redirect_to(8'hFF);
        while (!inst_valid && n < 10) begin tick(); n++; end
        total++; if (inst_pc !== 8'hFF || inst_data !== 8'h99) begin bad++; $display("FAIL wrap_inst got=%h/%h want=FF/99", inst_pc, inst_data); end
        total++; if (pc !== 8'h00) begin bad++; $display("FAIL wrap_pc got=%h want=00", pc); end
        stall = 1; inst_ready = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_req) reqs++;
        end
        total++; if (reqs != 0 || inst_valid !== 1'b0) begin bad++; $display("FAIL pause_req got=%0d/%b want=0/0", reqs, inst_valid); end
        stall = 0;
        n = 0;
        while (!mem_req && n < 10) begin tick(); n++; end
        total++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin bad++; $display("FAIL pause_addr got=%b/%h want=1/00", mem_req, mem_addr); end
        wait_halt("wrap");
        total++; if (pc !== 8'h03) begin bad++; $display("FAIL wrap_endpc got=%h want=03", pc); end
    endtask

    task automatic test_async_reset();
        mem[8'h50] = 8'h5A;
        ack_delay = 5; inst_ready = 1;
        redirect_to(8'h50);
        tick();
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL ar_req got=%b want=1", mem_req); end
        #3 reset = 1;
        #1;
        total++; if (mem_req !== 1'b0 || inst_valid !== 1'b0 || halted !== 1'b0) begin
            bad++; $display("FAIL ar_now got=%b/%b/%b want=0/0/0", mem_req, inst_valid, halted);
        end
        total++; if (pc !== 8'h00) begin bad++; $display("FAIL ar_pc got=%h want=00", pc); end
`ifdef FETCH_COUNT_EN
        total++; if (fetch_count !== 16'd0) begin bad++; $display("FAIL ar_fcnt got=%0d want=0", fetch_count); end
`endif
        #3 reset = 0;
        tick();
        ack_force = 1;
        tick();
        ack_force = 0;
        tick();
        total++; if (mem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== 8'h00) begin
            bad++; $display("FAIL ar_late got=%b/%b/%h want=0/0/00", mem_req, inst_valid, pc);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'hF0;
        test_reset();
        test_basic();
        test_delay();
        test_kill();
        test_flush();
        test_wrap_stall();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
